reflet_uart_tx_arbiter: RTL and testbench

Shares one reflet UART transmitter between `nreq` byte-stream requesters, for example the debug helper and the software UART peripheral. Arbitration is round-robin. A grant is held for a whole packet, which ends at a byte flagged `last` or when the hold timeout expires. The block drives the UART's `data_tx` and `start_transmit` inputs and watches its `end_transmit` output. It sits between the requesters and a single reflet_uart_uart instance.

---
 rtl/reflet_uart_arb_pkg.sv | 24 ++
 rtl/reflet_rr_picker.sv | 33 +++
 rtl/reflet_uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_reflet_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_uart_arb_pkg.sv
// Shared encodings and width helpers for the reflet UART transmit arbiter.
// The FSM state type, the default sizing and the pointer/counter width functions live here.
package reflet_uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } arb_state_t;

   localparam int unsigned NREQ_DEFAULT         = 2;
   localparam int unsigned HOLD_TIMEOUT_DEFAULT = 1024;

   // Both widths are clamped to 1 so degenerate sizings still give legal vectors.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/reflet_rr_picker.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping modulo nreq.
// Purely combinational, zero latency; it has no flow control of its own.
module reflet_rr_picker
   import reflet_uart_arb_pkg::*;
#(
   parameter int unsigned nreq  = NREQ_DEFAULT,
   parameter int unsigned ptr_w = ptr_width(nreq)
) (
   input  logic [nreq-1:0]  req,
   input  logic [ptr_w-1:0] ptr,
   output logic [ptr_w-1:0] index,
   output logic             found
);

   // Lowest set bit overall is the wrap-around fallback; the second pass
   // overrides it with the lowest set bit at or above ptr.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = nreq - 1; i >= 0; i--) begin
         if (req[i]) begin
            index = ptr_w'(i);
            found = 1'b1;
         end
      end
      for (int i = nreq - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(ptr))) begin
            index = ptr_w'(i);
         end
      end
   end

endmodule

// File: rtl/reflet_uart_tx_arbiter.sv
// Shares one UART transmitter between nreq requesters, round-robin, grant held per packet.
// 1 cycle from valid to uart_start; requesters hold their byte until the req_ack pulse.
module reflet_uart_tx_arbiter
   import reflet_uart_arb_pkg::*;
#(
   parameter int unsigned nreq         = NREQ_DEFAULT,
   parameter int unsigned hold_timeout = HOLD_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [nreq-1:0]   req_valid,
   input  logic [8*nreq-1:0] req_data,
   input  logic [nreq-1:0]   req_last,
   output logic [nreq-1:0]   req_ack,
   output logic [nreq-1:0]   grant,
   output logic              busy,
   output logic [7:0]        uart_data,
   output logic              uart_start,
   input  logic              uart_end
);

   localparam int unsigned PTR_W = ptr_width(nreq);
   localparam int unsigned CNT_W = cnt_width(hold_timeout);

   arb_state_t       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_found;
   logic             last_r;
   logic [CNT_W-1:0] hold_cnt;

   logic [PTR_W-1:0] sel_idx;
   logic [7:0]       sel_data;
   logic             sel_last;
   logic             sel_valid;

   reflet_rr_picker #(
      .nreq  (nreq),
      .ptr_w (PTR_W)
   ) u_picker (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .index (pick_idx),
      .found (pick_found)
   );

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (32'(p) == nreq - 1) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [nreq-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [nreq-1:0] v;
      v = '0;
      for (int i = 0; i < nreq; i++) v[i] = (32'(idx) == i);
      return v;
   endfunction

   // In IDLE the byte comes from the fresh pick, otherwise from the current owner.
   always_comb begin
      sel_idx   = (state == ST_IDLE) ? pick_idx : owner;
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < nreq; i++) begin
         if (32'(sel_idx) == i) begin
            sel_data  = req_data[8*i +: 8];
            sel_last  = req_last[i];
            sel_valid = req_valid[i];
         end
      end
   end

   assign busy       = (state != ST_IDLE);
   assign uart_start = (state == ST_SEND) && enable;
   assign req_ack    = uart_start ? grant : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         grant     <= '0;
         owner     <= '0;
         rr_ptr    <= '0;
         uart_data <= '0;
         last_r    <= 1'b0;
         hold_cnt  <= '0;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  owner     <= pick_idx;
                  grant     <= onehot(pick_idx);
                  uart_data <= sel_data;
                  last_r    <= sel_last;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: state <= ST_WAIT;
            ST_WAIT: begin
               if (uart_end) begin
                  if (last_r || (hold_timeout == 0)) begin
                     grant  <= '0;
                     rr_ptr <= next_ptr(owner);
                     state  <= ST_IDLE;
                  end else begin
                     hold_cnt <= '0;
                     state    <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (sel_valid) begin
                  uart_data <= sel_data;
                  last_r    <= sel_last;
                  hold_cnt  <= '0;
                  state     <= ST_SEND;
               end else if (hold_cnt == CNT_W'(hold_timeout - 1)) begin
                  grant  <= '0;
                  rr_ptr <= next_ptr(owner);
                  state  <= ST_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_ack_in_grant:  assert property (@(posedge clk) disable iff (reset) (req_ack & ~grant) == '0);
   a_start_single:  assert property (@(posedge clk) disable iff (reset) uart_start |=> !uart_start);
   a_end_in_wait:   assert property (@(posedge clk) disable iff (reset) uart_end |-> (state == ST_WAIT));

endmodule

// File: tb/tb_reflet_uart_tx_arbiter.sv
// Directed bench: two-requester arbiter with an 8-cycle hold and a three-requester
// arbiter that releases after every byte, both driven by hand-written vectors.
module tb_reflet_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        a_en = 1'b1;
   logic [1:0]  a_valid = '0;
   logic [15:0] a_data = '0;
   logic [1:0]  a_last = '0;
   logic [1:0]  a_ack;
   logic [1:0]  a_grant;
   logic        a_busy;
   logic [7:0]  a_udata;
   logic        a_ustart;
   logic        a_uend = 1'b0;

   logic        b_en = 1'b1;
   logic [2:0]  b_valid = '0;
   logic [7:0]  b_bytes [3];
   logic [23:0] b_data;
   logic [2:0]  b_last = '0;
   logic [2:0]  b_ack;
   logic [2:0]  b_grant;
   logic        b_busy;
   logic [7:0]  b_udata;
   logic        b_ustart;
   logic        b_uend = 1'b0;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n;
   logic [1:0]  bi;

   assign b_data = {b_bytes[2], b_bytes[1], b_bytes[0]};

   always #5 clk = ~clk;

   reflet_uart_tx_arbiter #(.nreq(2), .hold_timeout(8)) dut_a (
      .clk        (clk),
      .reset      (reset),
      .enable     (a_en),
      .req_valid  (a_valid),
      .req_data   (a_data),
      .req_last   (a_last),
      .req_ack    (a_ack),
      .grant      (a_grant),
      .busy       (a_busy),
      .uart_data  (a_udata),
      .uart_start (a_ustart),
      .uart_end   (a_uend)
   );

   reflet_uart_tx_arbiter #(.nreq(3), .hold_timeout(0)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .enable     (b_en),
      .req_valid  (b_valid),
      .req_data   (b_data),
      .req_last   (b_last),
      .req_ack    (b_ack),
      .grant      (b_grant),
      .busy       (b_busy),
      .uart_data  (b_udata),
      .uart_start (b_ustart),
      .uart_end   (b_uend)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in a SEND cycle of dut_a: the byte must be on the UART with its pulses.
   task automatic a_expect_send(input string tag, input logic [1:0] g, input logic [7:0] d);
      chk({tag, ".start"}, a_ustart, 1);
      chk({tag, ".grant"}, a_grant, g);
      chk({tag, ".ack"}, a_ack, g);
      chk({tag, ".data"}, a_udata, d);
   endtask

   // From a SEND cycle: step into WAIT, idle dly cycles, then deliver uart_end.
   task automatic a_finish(input string tag, input int dly);
      tick();
      chk({tag, ".wait_start"}, a_ustart, 0);
      chk({tag, ".wait_ack"}, a_ack, 0);
      repeat (dly) tick();
      a_uend = 1'b1;
      tick();
      a_uend = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      b_bytes[0] = 8'hA0;
      b_bytes[1] = 8'hB0;
      b_bytes[2] = 8'hC0;

      // reset state
      tick();
      tick();
      chk("rst.grant", a_grant, 0);
      chk("rst.busy", a_busy, 0);
      chk("rst.start", a_ustart, 0);
      chk("rst.data", a_udata, 0);
      chk("rst.ack", a_ack, 0);
      chk("rst.b_busy", b_busy, 0);
      reset = 1'b0;

      // single byte
      a_valid = 2'b01; a_data = 16'h0041; a_last = 2'b01;
      tick();
      a_expect_send("t1", 2'b01, 8'h41);
      chk("t1.busy", a_busy, 1);
      a_valid = 2'b00;
      a_finish("t1", 3);
      chk("t1.release", a_grant, 0);
      chk("t1.idle", a_busy, 0);
      // rr_ptr is now 1: with both valid, req1 wins
      a_valid = 2'b11; a_data = 16'h2211; a_last = 2'b11;
      tick();
      a_expect_send("t1.ptr", 2'b10, 8'h22);
      a_valid = 2'b01;
      a_finish("t1.ptr", 1);
      tick();
      a_expect_send("t1.next", 2'b01, 8'h11);
      a_valid = 2'b00;
      a_finish("t1.next", 1);

      // contention from reset, twice
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int r = 0; r < 2; r++) begin
         a_valid = 2'b11; a_data = 16'h55AA; a_last = 2'b11;
         tick();
         a_expect_send("t2.first", 2'b01, 8'hAA);
         a_valid = 2'b10;
         a_finish("t2.first", 1);
         chk("t2.gap_idle", a_grant, 0);
         tick();
         a_expect_send("t2.second", 2'b10, 8'h55);
         a_valid = 2'b00;
         a_finish("t2.second", 1);
      end

      // packet lock: req1 sends 3 bytes while req0 waits
      a_valid = 2'b10; a_data = 16'h0100; a_last = 2'b00;
      tick();
      a_expect_send("t3.b1", 2'b10, 8'h01);
      a_valid = 2'b11; a_data = 16'h0299; a_last = 2'b01;
      a_finish("t3.b1", 2);
      chk("t3.hold1_start", a_ustart, 0);
      chk("t3.hold1_grant", a_grant, 2'b10);
      tick();
      a_expect_send("t3.b2", 2'b10, 8'h02);
      a_data = 16'h0399; a_last = 2'b11;
      a_finish("t3.b2", 2);
      chk("t3.hold2_start", a_ustart, 0);
      tick();
      a_expect_send("t3.b3", 2'b10, 8'h03);
      a_valid = 2'b01;
      a_finish("t3.b3", 1);
      chk("t3.release", a_grant, 0);
      tick();
      a_expect_send("t3.req0", 2'b01, 8'h99);
      a_valid = 2'b00;
      a_finish("t3.req0", 1);

      // hold timeout of 8 cycles, then req1 takes over
      a_valid = 2'b01; a_data = 16'h7766; a_last = 2'b10;
      tick();
      a_expect_send("t4.b0", 2'b01, 8'h66);
      a_valid = 2'b10;
      a_finish("t4.b0", 2);
      n = 0;
      while (a_grant == 2'b01 && n < 20) begin
         n++;
         tick();
      end
      chk("t4.hold_cycles", n, 8);
      chk("t4.released", a_grant, 0);
      chk("t4.idle", a_busy, 0);
      tick();
      a_expect_send("t4.req1", 2'b10, 8'h77);
      a_valid = 2'b00;
      a_finish("t4.req1", 1);

      // enable dropped during SEND
      a_valid = 2'b01; a_data = 16'h005A; a_last = 2'b01;
      tick();
      a_en = 1'b0;
      #1;
      chk("t5.frozen_start", a_ustart, 0);
      chk("t5.frozen_ack", a_ack, 0);
      n = 0;
      repeat (5) begin
         tick();
         if (a_ustart) n++;
      end
      chk("t5.starts_while_off", n, 0);
      chk("t5.still_busy", a_busy, 1);
      a_en = 1'b1;
      #1;
      a_expect_send("t5.resume", 2'b01, 8'h5A);
      a_valid = 2'b00;
      tick();
      chk("t5.one_pulse", a_ustart, 0);
      // reset in WAIT wins over a presented request
      a_valid = 2'b01;
      reset = 1'b1;
      tick();
      chk("t5.rst_grant", a_grant, 0);
      chk("t5.rst_busy", a_busy, 0);
      chk("t5.rst_ack", a_ack, 0);
      chk("t5.rst_start", a_ustart, 0);
      a_valid = 2'b00;
      reset = 1'b0;
      tick();
      chk("t5.after_rst", a_grant, 0);

      // zero hold timeout: strict interleave req0, req1, req2, ...
      b_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         bi = 2'(k % 3);
         tick();
         chk("t6.start", b_ustart, 1);
         chk("t6.grant", b_grant, 3'b001 << bi);
         chk("t6.ack", b_ack, 3'b001 << bi);
         chk("t6.data", b_udata, b_bytes[bi]);
         b_bytes[bi] = b_bytes[bi] + 8'h01;
         tick();
         b_uend = 1'b1;
         tick();
         b_uend = 1'b0;
         chk("t6.release", b_grant, 0);
      end
      b_valid = 3'b000;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
